// File: rtl/unsigned_sqrt_seq.sv
// -----------------------------------------------------------------------------
// unsigned_sqrt_seq
//
// Sequential unsigned integer square root. It accepts a DATA_W-bit radicand
// and returns the floor root (ROOT_W = DATA_W/2 bits) and the remainder
// data_i - root^2 (ROOT_W+1 bits). The digit-by-digit method resolves one
// root bit per clock. It is the inverse of the 8-bit squarer in its default
// 16-bit configuration.
//
// Optional build macro: SQRT_ROUND_NEAREST_EN
//   When this macro is defined, a ROUND state is added after the last
//   iteration. root_o then reports the root rounded to nearest, saturating
//   at 2^ROOT_W-1. rem_o still reports the floor remainder. Latency becomes
//   ROOT_W+1 edges.
//   When the macro is undefined, root_o is the floor root and the latency is
//   ROOT_W edges.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   radicand valid
//   in_ready   out  block can accept a radicand (registered, depends on state only)
//   data_i     in   DATA_W   unsigned radicand, sampled on the accept edge
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts result
//   root_o     out  ROOT_W   floor (or rounded) square root
//   rem_o      out  ROOT_W+1 floor remainder, 0..2*floor_root
// -----------------------------------------------------------------------------
module unsigned_sqrt_seq #(
  parameter  int DATA_W = 16,
  localparam int ROOT_W = DATA_W / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] root_o,
  output logic [ROOT_W:0]   rem_o
);

  // The algorithm consumes the radicand two bits at a time.
  if ((DATA_W % 2) != 0 || DATA_W < 4) begin : g_bad_width
    $error("unsigned_sqrt_seq: DATA_W must be even and at least 4");
  end

  localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROOT_W - 1);

`ifdef SQRT_ROUND_NEAREST_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

  state_t            state_q;
  logic [DATA_W-1:0] rad_q;       // radicand, consumed from the MSB end
  logic [ROOT_W+1:0] rem_q;       // partial remainder, wide enough for the trial
  logic [ROOT_W-1:0] root_q;      // partial root
  logic [CNT_W-1:0]  cnt_q;       // iterations left after the current one
  logic              in_ready_q;
  logic              out_valid_q;
  logic [ROOT_W-1:0] root_o_q;
  logic [ROOT_W:0]   rem_o_q;

  // One digit-by-digit iteration.
  logic [ROOT_W+1:0] rem_shift_d;
  logic [ROOT_W+1:0] trial_d;
  logic [ROOT_W+1:0] rem_d;
  logic [ROOT_W-1:0] root_d;
  logic [DATA_W-1:0] rad_d;
  logic              take_d;

  always_comb begin
    // Before the shift, the remainder is at most 2*partial_root. The partial
    // root has at most ROOT_W-1 significant bits at that point, so the low
    // ROOT_W bits of rem_q hold all of the remainder.
    rem_shift_d = {rem_q[ROOT_W-1:0], rad_q[DATA_W-1 -: 2]};
    trial_d     = {root_q, 2'b01};
    take_d      = (rem_shift_d >= trial_d);
    rem_d       = take_d ? (rem_shift_d - trial_d) : rem_shift_d;
    root_d      = {root_q[ROOT_W-2:0], take_d};
    rad_d       = {rad_q[DATA_W-3:0], 2'b00};
  end

`ifdef SQRT_ROUND_NEAREST_EN
  // Round half-down: take root+1 only when the remainder exceeds the root.
  // The result is held at the maximum code instead of wrapping.
  logic [ROOT_W-1:0] root_rnd_d;
  always_comb begin
    root_rnd_d = root_q;
    if ((rem_q[ROOT_W:0] > {1'b0, root_q}) && (root_q != {ROOT_W{1'b1}})) begin
      root_rnd_d = root_q + 1'b1;
    end
  end
`endif

  // The top remainder bits only carry trial headroom. They never feed the
  // next shift.
  logic unused_rem_bits;
  assign unused_rem_bits = ^rem_q[ROOT_W+1:ROOT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      root_o_q    <= '0;
      rem_o_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            rad_q      <= data_i;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= CNT_INIT;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end

        S_CALC: begin
          rad_q  <= rad_d;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            rem_o_q <= rem_d[ROOT_W:0];
`ifdef SQRT_ROUND_NEAREST_EN
            state_q <= S_ROUND;
`else
            root_o_q    <= root_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
`endif
          end
        end

`ifdef SQRT_ROUND_NEAREST_EN
        S_ROUND: begin
          root_o_q    <= root_rnd_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
`endif

        S_DONE: begin
          // No same-cycle accept: in_ready comes back one cycle after the
          // output handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign root_o    = root_o_q;
  assign rem_o     = rem_o_q;

endmodule

// File: tb/tb_unsigned_sqrt_seq.sv
// -----------------------------------------------------------------------------
// Directed testbench for unsigned_sqrt_seq (DATA_W = 16).
// The expected values are written out by hand. The rounded expectations are
// used when SQRT_ROUND_NEAREST_EN is defined.
// -----------------------------------------------------------------------------
module tb_unsigned_sqrt_seq;

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int LAT = 9;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 8;
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_i;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  root_o;
  logic [8:0]  rem_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unsigned_sqrt_seq #(.DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_i   (data_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .root_o   (root_o),
    .rem_o    (rem_o)
  );

  // Drives one radicand and waits for its result. It then holds out_ready
  // low for up to max_stall cycles and completes the output handshake.
  // This task only drives the DUT and reports what it saw. The callers do
  // the checking.
  task automatic run_txn(input logic [15:0] d, input int max_stall,
                         output logic [7:0] r, output logic [8:0] m,
                         output int lat, output bit timed_out);
    int w;
    int stall;
    timed_out = 1'b0;
    r = '0;
    m = '0;
    lat = 0;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      timed_out = 1'b1;
      return;
    end
    in_valid = 1'b1;
    data_i   = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_i   = 16'($urandom);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      timed_out = 1'b1;
      return;
    end
    r = root_o;
    m = rem_o;
    stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || root_o !== 8'd0 || rem_o !== 9'd0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b root=%0d rem=%0d, want rdy=1 vld=0 root=0 rem=0",
               in_ready, out_valid, root_o, rem_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    $display("reset: rdy=%b vld=%b", in_ready, out_valid);
  endtask

  task automatic test_basic_144();
    int lat;
    in_valid = 1'b1; data_i = 16'd144; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; data_i = 16'hBEEF;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_in_ready_drop: got %b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL basic_latency: got %0d edges want %0d", lat, LAT);
    end
    n_vec++;
    if (root_o !== 8'd12 || rem_o !== 9'd0) begin
      n_err++;
      $display("FAIL basic_144: got root=%0d rem=%0d want root=12 rem=0", root_o, rem_o);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_handshake: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    $display("txn 144 -> root=%0d rem=%0d lat=%0d", root_o, rem_o, lat);
  endtask

  task automatic test_values();
    logic [15:0] d_tab   [5] = '{16'd0, 16'd65535, 16'd200, 16'd210, 16'd211};
    logic [7:0]  flr_tab [5] = '{8'd0, 8'd255, 8'd14, 8'd14, 8'd14};
    logic [7:0]  rnd_tab [5] = '{8'd0, 8'd255, 8'd14, 8'd14, 8'd15};
    logic [8:0]  rem_tab [5] = '{9'd0, 9'd510, 9'd4, 9'd14, 9'd15};
    logic [7:0]  r;
    logic [7:0]  want_r;
    logic [8:0]  m;
    int          lat;
    bit          to;
    for (int i = 0; i < 5; i++) begin
      run_txn(d_tab[i], 0, r, m, lat, to);
      want_r = RND ? rnd_tab[i] : flr_tab[i];
      n_vec++;
      if (to || r !== want_r || m !== rem_tab[i] || lat != LAT) begin
        n_err++;
        $display("FAIL value_%0d: got root=%0d rem=%0d lat=%0d timeout=%0d want root=%0d rem=%0d lat=%0d",
                 d_tab[i], r, m, lat, to, want_r, rem_tab[i], LAT);
      end
      $display("txn %0d -> root=%0d rem=%0d lat=%0d", d_tab[i], r, m, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want_r;
    int lat;
    want_r = RND ? 8'd224 : 8'd223;
    in_valid = 1'b1; data_i = 16'd50000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    // Offer a new radicand while the result is being held.
    in_valid = 1'b1; data_i = 16'd9;
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || root_o !== want_r || rem_o !== 9'd271 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold_%0d: got vld=%b root=%0d rem=%0d rdy=%b want vld=1 root=%0d rem=271 rdy=0",
                 i, out_valid, root_o, rem_o, in_ready, want_r);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    $display("txn 50000 held 20 cycles -> root=%0d rem=%0d", root_o, rem_o);
  endtask

  task automatic test_reset_abort();
    logic [7:0] r;
    logic [7:0] want_r;
    logic [8:0] m;
    int lat;
    bit to;
    bit seen;
    in_valid = 1'b1; data_i = 16'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_async: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL abort_no_result: got out_valid=1 after reset, want 0");
    end
    run_txn(16'd1000, 0, r, m, lat, to);
    want_r = RND ? 8'd32 : 8'd31;
    n_vec++;
    if (to || r !== want_r || m !== 9'd39) begin
      n_err++;
      $display("FAIL abort_rerun_1000: got root=%0d rem=%0d timeout=%0d want root=%0d rem=39", r, m, to, want_r);
    end
    $display("txn 1000 after abort -> root=%0d rem=%0d", r, m);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic [7:0] want_r;
    logic [8:0] m;
    logic [8:0] want_m;
    int lat;
    bit to;
    for (int k = 0; k < 256; k++) begin
      run_txn(16'(k * k), 3, r, m, lat, to);
      n_vec++;
      if (to || r !== 8'(k) || m !== 9'd0) begin
        n_err++;
        $display("FAIL square_%0d: got root=%0d rem=%0d timeout=%0d want root=%0d rem=0", k * k, r, m, to, k);
      end
      $display("txn %0d -> root=%0d rem=%0d", k * k, r, m);
    end
    for (int k = 0; k < 256; k++) begin
      run_txn(16'(k * k + 2 * k), 3, r, m, lat, to);
      want_m = 9'(2 * k);
      if (RND && k > 0 && k < 255) want_r = 8'(k + 1);
      else                         want_r = 8'(k);
      n_vec++;
      if (to || r !== want_r || m !== want_m) begin
        n_err++;
        $display("FAIL below_square_%0d: got root=%0d rem=%0d timeout=%0d want root=%0d rem=%0d",
                 k * k + 2 * k, r, m, to, want_r, want_m);
      end
      $display("txn %0d -> root=%0d rem=%0d", k * k + 2 * k, r, m);
    end
  endtask

  initial begin
    test_reset();
    test_basic_144();
    test_values();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
